ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Upstream stage of the synth: receives PS/2 keyboard frames (set-2 scan codes), checks framing and parity,
//  and tracks make/break codes into a 4-bit held-key vector that drives keys[3:0] of gui and recorder.
//  Also exposes every accepted byte (scan_code/scan_valid) and a frame_error pulse for debug/LED use.
// PARAMETERS
//  FILTER_LEN      8       consecutive identical synchronised samples needed before filtered ps2_clk changes
//  TIMEOUT_CYCLES  100000  cycles (2 ms @ 50 MHz) without a falling edge mid-frame before the frame is aborted
//  KEY0_CODE       8'h1C   set-2 make code mapped to keys[0] (A)
//  KEY1_CODE       8'h1B   make code for keys[1] (S)
//  KEY2_CODE       8'h23   make code for keys[2] (D)
//  KEY3_CODE       8'h2B   make code for keys[3] (F)
// PORTS
//  clock        in   1  system clock, 50 MHz
//  reset        in   1  asynchronous, active-low reset
//  ps2_clk      in   1  raw PS/2 clock from pin, asynchronous
//  ps2_dat      in   1  raw PS/2 data from pin, asynchronous
//  keys         out  4  held state of the four mapped keys, 1 = held
//  scan_code    out  8  last accepted byte, held until the next accepted byte
//  scan_valid   out  1  one-cycle pulse when scan_code updates
//  frame_error  out  1  one-cycle pulse on parity/stop/timeout error
// BEHAVIOUR
//  Reset (async assert, sync release): keys=0, scan_code=0, scan_valid=0, frame_error=0, FSM=IDLE,
//   break_pending=0, ext_pending=0, filtered clk=1, timeout counter=0.
//  Input conditioning: ps2_clk and ps2_dat each pass through 2 flops. Filtered clk toggles only after
//   FILTER_LEN consecutive samples differ from its current value. A falling edge = filtered clk 1->0;
//   the synchronised ps2_dat is sampled in that same cycle.
//  Frame FSM, one transition per falling edge:
//   IDLE:   sampled 0 (start) -> DATA with bit count 0; sampled 1 -> stay IDLE, no error.
//   DATA:   shift bit into the byte LSB first; after the 8th bit -> PARITY.
//   PARITY: store bit -> STOP.
//   STOP:   goes to IDLE. Accept the byte if stop==1 and (data ^ parity) has an odd number of ones;
//           otherwise pulse frame_error for 1 cycle and drop the byte (decoder state unchanged).
//  Timeout: in any state other than IDLE, a counter counts cycles since the last falling edge. At
//   TIMEOUT_CYCLES -> IDLE, pulse frame_error, drop partial byte. Counter clears on each falling edge and in IDLE.
//  Latency: scan_valid pulses exactly 1 cycle after the falling edge that samples the stop bit.
//   scan_code and keys update on that same cycle.
//  Decode of each accepted byte B:
//   B==8'hF0: break_pending=1, keys unchanged.
//   B==8'hE0: ext_pending=1, keys unchanged.
//   B==KEYn_CODE and ext_pending==0: keys[n] = ~break_pending.
//   Any other B, including an extended one: keys unchanged.
//   After any byte other than F0/E0: clear break_pending and ext_pending.
//   Typematic repeats (a make code while the key is already held): keys[n] stays 1, no glitch.
//  Width/limits: bit counter 3 bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits, saturating.
//   Filter counter $clog2(FILTER_LEN+1) bits.
//  Reset mid-frame discards the partial frame and all pending flags. No host-to-device transmit; lines are input-only.
// TESTING
//  1 Send frame 0x1C (bit period 4000 cycles, odd parity) -> scan_valid 1 cycle after the stop edge,
//    scan_code=8'h1C, keys=4'b0001.
//  2 Send 0x1C, 0x23, then F0,1C -> keys goes 0001 -> 0101 -> 0100; scan_valid pulses 4 times;
//    keys does not change on the F0 byte.
//  3 Send 0x2B with the parity bit flipped -> frame_error pulses once, no scan_valid, keys and scan_code unchanged.
//  4 Send start bit + 4 data bits, then idle clk high for 100000 cycles -> frame_error pulses at timeout;
//    a following 0x1B frame is accepted and gives keys[1]=1.
//  5 Add 3-cycle low glitches on ps2_clk between real edges (FILTER_LEN=8), and send E0,1C -> no extra bits
//    shifted; scan_code=8'h1C with keys[0]=0 (extended code ignored).
//  6 Hold 0x23 make (keys=0100) and assert reset mid-frame -> all outputs 0 immediately;
//    after release, a clean 0x23 frame gives keys=4'b0100.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: conditions the raw lines, deframes 11-bit frames and
// tracks make/break codes of four mapped keys into a held-key vector.
module ps2_key_decoder #(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] KEY0_CODE      = 8'h1C,
  parameter logic [7:0] KEY1_CODE      = 8'h1B,
  parameter logic [7:0] KEY2_CODE      = 8'h23,
  parameter logic [7:0] KEY3_CODE      = 8'h2B
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] keys,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          clk_p0, clk_p1, dat_p0, dat_p1;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          accept, reject;
  logic          break_pending, ext_pending;
  logic [3:0]    keys_d;
  logic          brk_d, ext_d;

  // Odd parity over data plus parity bit.
  function automatic logic frame_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Stage p0/p1: two-flop synchronisers, idle-high lines
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_dat;
      dat_p1 <= dat_p0;
    end
  end

  // Clock deglitch: the filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign fall = filt_clk && !clk_p1 && (filt_cnt == FILT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_p1 != filt_clk) begin
      if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Frame FSM
  assign timeout = (state_q != IDLE) && !fall && (to_cnt == TO_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      reject  = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_p1) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (dat_p1 && frame_parity_ok(shift_q, par_q)) accept = 1'b1;
          else                                           reject = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (fall && state_q == IDLE) bit_cnt <= '0;
      else if (fall && state_q == DATA) bit_cnt <= bit_cnt + 3'd1;
      if (state_q == IDLE || fall) to_cnt <= '0;
      else if (to_cnt != TO_MAX)   to_cnt <= to_cnt + TW'(1);
    end
  end

  // Shift register and parity bit are pure data; a stale partial byte is never accepted
  always_ff @(posedge clock) begin
    if (fall && state_q == DATA)   shift_q <= {dat_p1, shift_q[7:1]};
    if (fall && state_q == PARITY) par_q   <= dat_p1;
  end

  // Make/break decode of an accepted byte
  always_comb begin
    keys_d = keys;
    brk_d  = break_pending;
    ext_d  = ext_pending;
    if (shift_q == 8'hF0) begin
      brk_d = 1'b1;
    end else if (shift_q == 8'hE0) begin
      ext_d = 1'b1;
    end else begin
      if (!ext_pending) begin
        if (shift_q == KEY0_CODE) keys_d[0] = ~break_pending;
        if (shift_q == KEY1_CODE) keys_d[1] = ~break_pending;
        if (shift_q == KEY2_CODE) keys_d[2] = ~break_pending;
        if (shift_q == KEY3_CODE) keys_d[3] = ~break_pending;
      end
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
  end

  // Output stage: registered one cycle after the stop-bit edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      keys          <= '0;
      scan_code     <= '0;
      scan_valid    <= 1'b0;
      frame_error   <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
    end else begin
      scan_valid  <= accept;
      frame_error <= reject;
      if (accept) begin
        scan_code     <= shift_q;
        keys          <= keys_d;
        break_pending <= brk_d;
        ext_pending   <= ext_d;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a byte-level make/break model plus per-cycle output compare.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TO   = 2000;
  localparam int HALF = 100;
  localparam int GAP  = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] keys;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;

  ps2_key_decoder #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .keys       (keys),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_error(frame_error)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [3:0] exp_keys = '0;
  logic [7:0] exp_code = '0;
  logic [3:0] nxt_keys = '0;
  logic [7:0] nxt_code = '0;
  bit         brk = 0, ext = 0;
  int         sv_cyc = -1;
  bit         fe_armed = 0;
  int         fe_lo = 0, fe_hi = 0;
  int         sv_count = 0, fe_count = 0;
  int         last_fall = 0;
  logic [7:0] key_codes [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Effect of one accepted byte on the held-key set
  task automatic model_byte(input logic [7:0] b);
    nxt_keys = exp_keys;
    nxt_code = b;
    if (b == 8'hF0) brk = 1;
    else if (b == 8'hE0) ext = 1;
    else begin
      for (int n = 0; n < 4; n++)
        if (b == key_codes[n] && !ext) nxt_keys[n] = !brk;
      brk = 0;
      ext = 0;
    end
  endtask

  // Compare process: every cycle
  always @(negedge clock) begin
    if (sv_cyc >= 0 && cyc == sv_cyc) begin
      exp_keys = nxt_keys;
      exp_code = nxt_code;
    end
    check("scan_valid", {31'b0, scan_valid}, {31'b0, (sv_cyc >= 0 && cyc == sv_cyc)});
    if (scan_valid) sv_count++;
    if (sv_cyc >= 0 && cyc >= sv_cyc) sv_cyc = -1;
    if (frame_error) begin
      fe_count++;
      check("frame_error_window", {31'b0, (fe_armed && cyc >= fe_lo && cyc <= fe_hi)}, 32'd1);
      fe_armed = 0;
    end else if (fe_armed && cyc > fe_hi) begin
      check("frame_error_deadline", {31'b0, frame_error}, 32'd1);
      fe_armed = 0;
    end
    check("keys", {28'b0, keys}, {28'b0, exp_keys});
    check("scan_code", {24'b0, scan_code}, {24'b0, exp_code});
  end

  // kind: 0 plain bit, 1 stop bit of a good frame, 2 stop bit of a bad frame
  task automatic send_bit(input logic b, input bit glitch, input int kind);
    @(posedge clock); #1 ps2_dat = b;
    repeat (HALF / 2) @(posedge clock);
    if (glitch) begin
      #1 ps2_clk = 1'b0;
      repeat (3) @(posedge clock);
      #1 ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(posedge clock);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    // 2 sync flops + FILT filter samples + 1 output register
    if (kind == 1) sv_cyc = cyc + 3 + FILT - 1;
    if (kind == 2) begin
      fe_lo = cyc + 3 + FILT - 1;
      fe_hi = fe_lo;
      fe_armed = 1;
    end
    repeat (HALF) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
    logic par;
    par = ~(^b) ^ flip_par;
    if (!flip_par) model_byte(b);
    send_bit(1'b0, glitch, 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch, 0);
    send_bit(par, glitch, 0);
    send_bit(1'b1, glitch, flip_par ? 2 : 1);
    repeat (GAP) @(posedge clock);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 0, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_keys", {28'b0, keys}, 32'h0);
    check("rst_scan_code", {24'b0, scan_code}, 32'h0);
    check("rst_scan_valid", {31'b0, scan_valid}, 32'h0);
    check("rst_frame_error", {31'b0, frame_error}, 32'h0);
    repeat (20) @(posedge clock);

    // 1: single make code
    sv_count = 0;
    send_frame(8'h1C, 0, 0);
    check("t1_keys", {28'b0, keys}, 32'b0001);
    check("t1_code", {24'b0, scan_code}, 32'h1C);
    check("t1_pulses", sv_count, 1);

    // 2: typematic, second key, break
    sv_count = 0;
    send_frame(8'h1C, 0, 0);
    check("t2_repeat_keys", {28'b0, keys}, 32'b0001);
    send_frame(8'h23, 0, 0);
    check("t2_keys_a", {28'b0, keys}, 32'b0101);
    send_frame(8'hF0, 0, 0);
    check("t2_keys_f0", {28'b0, keys}, 32'b0101);
    send_frame(8'h1C, 0, 0);
    check("t2_keys_b", {28'b0, keys}, 32'b0100);
    check("t2_pulses", sv_count, 4);

    // 3: parity error
    sv_count = 0; fe_count = 0;
    send_frame(8'h2B, 1, 0);
    check("t3_fe_pulses", fe_count, 1);
    check("t3_sv_pulses", sv_count, 0);
    check("t3_keys", {28'b0, keys}, 32'b0100);
    check("t3_code", {24'b0, scan_code}, 32'h1C);

    // 4: timeout mid-frame, then recovery
    fe_count = 0;
    send_partial(8'h55, 4);
    fe_lo = last_fall + TO;
    fe_hi = last_fall + TO + 20;
    fe_armed = 1;
    repeat (TO + 100) @(posedge clock);
    check("t4_fe_pulses", fe_count, 1);
    send_frame(8'h1B, 0, 0);
    check("t4_keys", {28'b0, keys}, 32'b0110);
    check("t4_code", {24'b0, scan_code}, 32'h1B);

    // 5: clock glitches, extended code ignored
    sv_count = 0;
    send_frame(8'hE0, 0, 1);
    check("t5_code_e0", {24'b0, scan_code}, 32'hE0);
    send_frame(8'h1C, 0, 1);
    check("t5_code", {24'b0, scan_code}, 32'h1C);
    check("t5_keys", {28'b0, keys}, 32'b0110);
    check("t5_pulses", sv_count, 2);

    // 6: reset mid-frame
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1B, 0, 0);
    check("t6_held", {28'b0, keys}, 32'b0100);
    send_partial(8'h23, 3);
    @(posedge clock); #1 reset = 1'b0;
    exp_keys = '0; exp_code = '0; brk = 0; ext = 0; sv_cyc = -1; fe_armed = 0;
    ps2_dat = 1'b1;
    @(negedge clock);
    check("t6_rst_keys", {28'b0, keys}, 32'h0);
    check("t6_rst_code", {24'b0, scan_code}, 32'h0);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    repeat (20) @(posedge clock);
    send_frame(8'h23, 0, 0);
    check("t6_keys", {28'b0, keys}, 32'b0100);
    check("t6_code", {24'b0, scan_code}, 32'h23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
